// File: rtl/spi_reg_tx.sv
// SPI mode-0 write-only master: serialises an MSB-aligned word of up to MAX_BITS bits
// at a programmable SCLK half-period, then reports completion with a one-cycle pulse.
module spi_reg_tx #(
    parameter int MAX_BITS = 32,
    parameter int NB_W     = 6,
    parameter int DIV_W    = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [MAX_BITS-1:0] i_data,
    input  logic [NB_W-1:0]     i_nbits,
    input  logic [DIV_W-1:0]    i_div,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_csb,
    output logic                o_sclk,
    output logic                o_mosi
);

    localparam logic [NB_W-1:0] MAX_N = NB_W'(MAX_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_TAIL,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [NB_W-1:0]     bits_q, bits_d;
    logic [MAX_BITS-1:0] sr_q, sr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                csb_q, csb_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [NB_W-1:0]     n_req;
    logic                phase_end;

    // The half-period counter runs 0..div, so div = 2^DIV_W-1 gives exactly 2^DIV_W cycles.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q + DIV_W'(1);
        bits_d    = bits_q;
        sr_d      = sr_q;
        n_req     = (i_nbits > MAX_N) ? MAX_N : i_nbits;
        phase_end = (cnt_q == div_q);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_start) begin
                    if (n_req != '0) begin
                        state_d = S_LO;
                        div_d   = i_div;
                        bits_d  = n_req;
                        sr_d    = i_data;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LO: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (bits_q > NB_W'(1)) begin
                        state_d = S_LO;
                        bits_d  = bits_q - NB_W'(1);
                        sr_d    = {sr_q[MAX_BITS-2:0], 1'b0};
                    end else begin
                        state_d = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Pins are decoded from the next state so they come straight out of flops.
        busy_d = (state_d == S_LO) || (state_d == S_HI) || (state_d == S_TAIL) || (state_d == S_GAP);
        csb_d  = !((state_d == S_LO) || (state_d == S_HI) || (state_d == S_TAIL));
        sclk_d = (state_d == S_HI);
        mosi_d = !csb_d && sr_d[MAX_BITS-1];
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            bits_q  <= '0;
            sr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            csb_q   <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_csb  = csb_q;
    assign o_sclk = sclk_q;
    assign o_mosi = mosi_q;

endmodule

// File: tb/tb_spi_reg_tx.sv
// Randomised bench for spi_reg_tx: every cycle of every frame is compared against a
// waveform computed from the frame timing formulas, plus a mode-0 receiver on the pins.
module tb_spi_reg_tx;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_data;
    logic [5:0]  i_nbits;
    logic [7:0]  i_div;
    logic        o_busy;
    logic        o_done;
    logic        o_csb;
    logic        o_sclk;
    logic        o_mosi;

    int checkCount = 0;
    int passCount  = 0;

    spi_reg_tx #(.MAX_BITS(32), .NB_W(6), .DIV_W(8)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_data  (i_data),
        .i_nbits (i_nbits),
        .i_div   (i_div),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_csb   (o_csb),
        .o_sclk  (o_sclk),
        .o_mosi  (o_mosi)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    function automatic logic [4:0] pins();
        return {o_csb, o_sclk, o_mosi, o_busy, o_done};
    endfunction

    // Expected {csb,sclk,mosi,busy,done} in cycle r after the accepting edge (r=1 is first).
    function automatic logic [4:0] expectedOut(int r, int n, int h, logic [31:0] d);
        int k;
        if (n == 0) return (r == 1) ? 5'b10001 : 5'b10000;
        if (r < 1 || r > (2*n+2)*h + 1) return 5'b10000;
        if (r == (2*n+2)*h + 1) return 5'b10001;
        if (r > (2*n+1)*h) return 5'b10010;
        if (r <= 2*n*h) begin
            k = (r - 1) / (2*h);
            return {1'b0, 1'(((r - 1) / h) % 2), d[31-k], 2'b10};
        end
        return {1'b0, 1'b0, d[31-(n-1)], 2'b10};
    endfunction

    task automatic applyStimulus(input logic [31:0] data, input int nbits, input int div, input bit noise);
        int n, h, last, csbLow;
        logic [31:0] capture;
        logic prevSclk;
        n = (nbits > 32) ? 32 : nbits;
        h = div + 1;
        last = (n == 0) ? 1 : (2*n+2)*h + 1;
        csbLow = 0;
        capture = '0;
        prevSclk = 1'b0;
        i_data = data;
        i_nbits = 6'(nbits);
        i_div = 8'(div);
        i_start = 1'b1;
        for (int r = 1; r <= last; r++) begin
            tick();
            checkOutput($sformatf("cyc%0d", r), 32'(pins()), 32'(expectedOut(r, n, h, data)));
            if (!o_csb) csbLow++;
            if (o_sclk && !prevSclk && !o_csb) capture = {capture[30:0], o_mosi};
            prevSclk = o_sclk;
            i_data = $urandom;
            i_nbits = 6'($urandom);
            i_div = 8'($urandom);
            i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        tick();
        checkOutput("idle", 32'(pins()), 32'h10);
        i_start = 1'b0;
        if (n > 0) checkOutput("rx", capture, data >> (32 - n));
        checkOutput("csbLen", 32'(csbLow), 32'((n == 0) ? 0 : (2*n+1)*h));
    endtask

    initial begin
        logic [31:0] d;
        int runLen;
        bit seenLow;

        i_reset = 1'b1;
        i_start = 1'b0;
        i_data = '0;
        i_nbits = '0;
        i_div = '0;
        tick();
        checkOutput("rst0", 32'(pins()), 32'h10);
        tick();
        i_reset = 1'b0;
        tick();
        checkOutput("rstIdle", 32'(pins()), 32'h10);

        applyStimulus(32'hA5000000, 8, 0, 1'b0);
        applyStimulus(32'hDEADBEEF, 40, 2, 1'b1);
        applyStimulus($urandom, 0, 0, 1'b0);
        applyStimulus($urandom, 1, 255, 1'b0);
        for (int i = 0; i < 20; i++)
            applyStimulus($urandom, int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), 1'b1);

        // Start held high: frames repeat every 12 cycles with CSB high for 3 between them.
        d = $urandom;
        i_data = d;
        i_nbits = 6'd4;
        i_div = 8'd0;
        i_start = 1'b1;
        runLen = 0;
        seenLow = 1'b0;
        for (int t = 1; t <= 36; t++) begin
            tick();
            checkOutput("held", 32'(pins()), 32'(expectedOut(((t - 1) % 12) + 1, 4, 1, d)));
            if (!o_csb) begin
                if (seenLow && runLen > 0) checkOutput("gapLen", 32'(runLen), 32'd3);
                runLen = 0;
                seenLow = 1'b1;
            end else if (seenLow) begin
                runLen++;
            end
        end
        i_start = 1'b0;
        for (int t = 0; t < 16; t++) tick();

        // Reset while bit 5 of a 16-bit, H=4 frame is on the wire.
        d = $urandom;
        i_data = d;
        i_nbits = 6'd16;
        i_div = 8'd3;
        i_start = 1'b1;
        for (int r = 1; r <= 41; r++) begin
            tick();
            checkOutput("preRst", 32'(pins()), 32'(expectedOut(r, 16, 4, d)));
            i_start = 1'b0;
        end
        i_reset = 1'b1;
        tick();
        checkOutput("midRst", 32'(pins()), 32'h10);
        i_reset = 1'b0;
        for (int t = 0; t < 150; t++) begin
            tick();
            checkOutput("postRst", 32'(pins()), 32'h10);
        end
        applyStimulus($urandom, 16, 3, 1'b0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/spi_reg_tx.md
Name: spi_reg_tx

Overview:
- SPI mode-0 transmitter (write-only master) that drives the design's register and vector SPI receive ports (csb/sclk/mosi) from a parallel request.
- Sits on the SoC/test side of those ports so that firmware logic and cocotb benches can issue register and vector writes without bit-banging the LA lines.
- Serialises a variable-length word MSB-first at a programmable SCLK rate.
- Reports busy and completion.

Parameters:
- MAX_BITS, 32: width of i_data and the shift register; largest frame length.
- NB_W, 6: width of i_nbits; must satisfy 2^NB_W > MAX_BITS.
- DIV_W, 8: width of i_div.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_start  input  1  request pulse; sampled only when idle
- i_data  input  MAX_BITS  frame payload, MSB-aligned; bit MAX_BITS-1 is sent first
- i_nbits  input  NB_W  number of bits to send
- i_div  input  DIV_W  SCLK half-period = i_div+1 i_clk cycles
- o_busy  output  1  transaction in progress
- o_done  output  1  one-cycle completion pulse
- o_csb  output  1  SPI chip select, active low
- o_sclk  output  1  SPI clock, idles low
- o_mosi  output  1  SPI data out

Behaviour:
- Reset: on i_reset high at an edge, the next cycle shows o_csb=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0, state IDLE. Reset mid-frame aborts immediately: no o_done, no partial CSB glitch beyond that edge.
- Definitions: H = latched i_div+1; N = latched min(i_nbits, MAX_BITS).
- Request latching: i_data, i_nbits and i_div are latched on the accepting edge. Later input changes have no effect on the frame in flight.
- States:
  - IDLE
  - LO: csb low, sclk low, mosi = current bit; lasts H cycles
  - HI: sclk high; lasts H cycles
  - TAIL: sclk low after the last HI; lasts H cycles
  - GAP: csb high; lasts H cycles
  - DONE: single cycle
- Transitions:
  - IDLE→LO on i_start when N>0.
  - LO→HI.
  - HI→LO if bits remain, else HI→TAIL.
  - TAIL→GAP.
  - GAP→DONE.
  - DONE→IDLE.
- Shift register: loaded with i_data at accept. o_mosi = sr[MAX_BITS-1]. The register shifts left by one on each HI→LO transition (the SCLK falling edge), so MOSI is stable for a full H before and after each rising edge.
- Timing, i_start high in cycle T with the block idle:
  - o_busy=1 and o_csb=0 from T+1.
  - o_sclk high in cycles T+1+(2k+1)H .. T+(2k+2)H for k=0..N-1.
  - o_csb low through T+(2N+1)H.
  - GAP (csb=1, busy=1) from T+(2N+1)H+1 to T+(2N+2)H.
  - o_done=1 and o_busy=0 in cycle T+(2N+2)H+1.
- o_mosi outside LO/HI/TAIL: driven 0. In TAIL it holds the last shifted value; receivers ignore it.
- N=0: no frame. o_csb stays 1, o_busy stays 0, and o_done pulses in cycle T+1.
- i_nbits > MAX_BITS: clamped to MAX_BITS.
- i_start while busy: ignored, never queued.
- i_start in the DONE cycle: ignored. i_start in the cycle after DONE (IDLE): accepted. The minimum inter-frame CSB-high time is therefore H+2 cycles.
- Counters: half-period counter DIV_W bits, bit counter NB_W bits. Neither may wrap: with i_div = 2^DIV_W-1, H = 2^DIV_W exactly.
- All outputs are registered; no combinational path from inputs to SPI pins.

Test Plan:
- Reset behaviour: i_reset during idle and during a frame (i_div=3, N=16, assert reset at bit 5) → next cycle o_csb=1, o_sclk=0, o_mosi=0, o_busy=0; no o_done ever; a fresh i_start afterwards sends correctly.
- 8-bit frame at maximum rate: i_data=32'hA5000000, i_nbits=8, i_div=0, i_start at T → o_csb low T+1..T+17; SCLK rises at T+2,4,…,16; a mode-0 bench receiver captures 8'hA5; o_done at T+19 only.
- Full-width, slow frame: i_data=32'hDEADBEEF, i_nbits=40 (clamped), i_div=2 → 32 SCLK pulses, each high 3 cycles; captured 32'hDEADBEEF; o_csb low exactly 65×3=195 cycles.
- Zero-length request: i_nbits=0, i_start at T → o_done at T+1, o_csb never low, o_busy never high.
- Start handling: i_start held high continuously with N=4, i_div=0 → back-to-back frames with o_csb high for exactly 3 cycles between them. i_data changed mid-frame → frame in flight unaffected.
- Loopback: drive the design's register SPI receiver with this block, writing a 6-bit address plus payload → the target register updates to the written value after CSB rises.
